// File: rtl/differentiator_pkg.sv
// differentiator_pkg: shared dsp helpers for the differentiator and its delay line.
//   max_signed/min_signed : two's-complement limits of a given width
//   sign_ext              : sign-extend the low 'width' bits of a word to int
//   clamp_signed          : saturate an int to the range of a given width
package differentiator_pkg;

    localparam int unsigned MAX_DIFF_DELAY = 16;

    // Largest value representable in a signed field of 'width' bits.
    function automatic int max_signed(input int unsigned width);
        int r;
        r = (1 << (width - 1)) - 1;
        return r;
    endfunction

    // Smallest value representable in a signed field of 'width' bits.
    function automatic int min_signed(input int unsigned width);
        int r;
        r = -(1 << (width - 1));
        return r;
    endfunction

    // Treat bit width-1 of x as the sign bit and extend to 32 bits.
    function automatic int sign_ext(input logic [31:0] x, input int unsigned width);
        int r;
        r = int'(x << (32 - width));
        return r >>> (32 - width);
    endfunction

    // Clamp v into the signed range of 'width' bits.
    function automatic int clamp_signed(input int v, input int unsigned width);
        int r;
        if (v > max_signed(width)) begin
            r = max_signed(width);
        end else if (v < min_signed(width)) begin
            r = min_signed(width);
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/differentiator_delay_line.sv
// sample_delay_line: clock-enabled shift register of DEPTH samples.
//   clk      : rising-edge clock
//   rst      : synchronous active-high clear of every stage
//   en       : shift strobe; data_in enters stage 0 when high
//   data_in  : DATA_WIDTH sample
//   data_out : oldest stage (DEPTH-1)
module sample_delay_line
    import differentiator_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out
);

    logic [DATA_WIDTH-1:0] r_dline [DEPTH];

    // Shift only on strobe so history is indexed by accepted sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_dline[i] <= '0;
            end
        end else if (en) begin
            r_dline[0] <= data_in;
            for (int i = 1; i < int'(DEPTH); i++) begin
                r_dline[i] <= r_dline[i-1];
            end
        end
    end

    assign data_out = r_dline[DEPTH-1];

endmodule

// File: rtl/differentiator.sv
// differentiator: streaming comb stage, data_out = data_in - data_in delayed by
// DIFF_DELAY accepted samples, two's-complement signed.
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset, priority over en
//   en         : sample strobe
//   data_in    : INPUT_DATA_WIDTH signed sample
//   data_out   : OUTPUT_DATA_WIDTH signed difference, registered
//   data_valid : one-cycle qualifier, high once DIFF_DELAY samples of history exist
// Build option DIFFERENTIATOR_SATURATE_EN: clamp instead of wrap when the output
// is narrower than INPUT_DATA_WIDTH+1 (wrap is the CIC-compatible default).
module differentiator
    import differentiator_pkg::*;
#(
    parameter int unsigned INPUT_DATA_WIDTH  = 8,
    parameter int unsigned OUTPUT_DATA_WIDTH = 9,
    parameter int unsigned DIFF_DELAY        = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                en,
    input  logic signed [INPUT_DATA_WIDTH-1:0]  data_in,
    output logic signed [OUTPUT_DATA_WIDTH-1:0] data_out,
    output logic                                data_valid
);

    localparam int unsigned DW     = INPUT_DATA_WIDTH + 1;
    localparam int unsigned OW     = OUTPUT_DATA_WIDTH;
    localparam int unsigned FILL_W = $clog2(DIFF_DELAY + 1);

    logic [INPUT_DATA_WIDTH-1:0] w_oldest;
    logic signed [DW-1:0]        w_diff;
    logic signed [OW-1:0]        w_resized;
    logic                        w_primed;

    logic signed [OW-1:0]        r_data_out;
    logic                        r_data_valid;
    logic [FILL_W-1:0]           r_fill;

    sample_delay_line #(
        .DATA_WIDTH (INPUT_DATA_WIDTH),
        .DEPTH      (DIFF_DELAY)
    ) u_dline (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .data_in  (data_in),
        .data_out (w_oldest)
    );

    // One extra bit makes every difference of two in-range samples exact.
    assign w_diff = {data_in[INPUT_DATA_WIDTH-1], data_in}
                  - {w_oldest[INPUT_DATA_WIDTH-1], w_oldest};

    // Fit the exact difference to the output width.
    generate
        if (OW > DW) begin : g_widen
            assign w_resized = {{(OW - DW){w_diff[DW-1]}}, w_diff};
        end else if (OW == DW) begin : g_exact
            assign w_resized = w_diff;
        end else begin : g_narrow
`ifdef DIFFERENTIATOR_SATURATE_EN
            assign w_resized = OW'(clamp_signed(sign_ext(32'(w_diff), DW), OW));
`else
            assign w_resized = w_diff[OW-1:0];
`endif
        end
    endgenerate

    // Compared before increment, so sample index DIFF_DELAY is the first valid one.
    assign w_primed = (r_fill == FILL_W'(DIFF_DELAY));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_fill       <= '0;
        end else if (en) begin
            r_data_out   <= w_resized;
            r_data_valid <= w_primed;
            if (!w_primed) begin
                r_fill <= r_fill + FILL_W'(1);
            end
        end else begin
            r_data_valid <= 1'b0;
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;

endmodule

// File: tb/tb_differentiator.sv
// tb_differentiator: directed stimulus shared by three differentiator builds
// (M=1 lossless, M=2 lossless, M=1 narrowed to 8 bits) checked every cycle
// against a sample-history model, plus literal expectations.
module tb_differentiator;

`ifdef DIFFERENTIATOR_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    localparam int MS [3] = '{1, 2, 1};
    localparam int OWS[3] = '{9, 9, 8};

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en  = 1'b0;
    logic signed [7:0] din = '0;

    logic signed [8:0] out0, out1;
    logic signed [7:0] out2;
    logic              val0, val1, val2;

    differentiator #(.INPUT_DATA_WIDTH(8), .OUTPUT_DATA_WIDTH(9), .DIFF_DELAY(1)) dut_m1 (
        .clk(clk), .rst(rst), .en(en), .data_in(din), .data_out(out0), .data_valid(val0));
    differentiator #(.INPUT_DATA_WIDTH(8), .OUTPUT_DATA_WIDTH(9), .DIFF_DELAY(2)) dut_m2 (
        .clk(clk), .rst(rst), .en(en), .data_in(din), .data_out(out1), .data_valid(val1));
    differentiator #(.INPUT_DATA_WIDTH(8), .OUTPUT_DATA_WIDTH(8), .DIFF_DELAY(1)) dut_nar (
        .clk(clk), .rst(rst), .en(en), .data_in(din), .data_out(out2), .data_valid(val2));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int hist[$];
    int nxt_out[3] = '{0, 0, 0};
    int nxt_val[3] = '{0, 0, 0};
    int exp_out[3] = '{0, 0, 0};
    int exp_val[3] = '{0, 0, 0};
    bit started = 1'b0;
    int lit_sel = 0;
    int lit_out = 0;
    int lit_val = 0;

    // Fit an exact difference into an outw-bit signed result.
    function automatic int model_resize(input int diff, input int outw);
        int lo, hi, m, r;
        lo = -(1 << (outw - 1));
        hi = (1 << (outw - 1)) - 1;
        if (diff >= lo && diff <= hi) return diff;
        if (SAT) return (diff > hi) ? hi : lo;
        m = 1 << outw;
        r = ((diff % m) + m) % m;
        if (r > hi) r = r - m;
        return r;
    endfunction

    // Drive one clock of stimulus and advance the model across that edge.
    task automatic cyc(input bit r, input bit e, input int d,
                       input int ls = 0, input int lo = 0, input int lv = 0);
        int old;
        rst = r;
        en  = e;
        din = 8'(d);
        if (r) begin
            hist.delete();
            for (int i = 0; i < 3; i++) begin
                nxt_out[i] = 0;
                nxt_val[i] = 0;
            end
        end else if (e) begin
            for (int i = 0; i < 3; i++) begin
                old = (hist.size() >= MS[i]) ? hist[hist.size() - MS[i]] : 0;
                nxt_out[i] = model_resize(d - old, OWS[i]);
                nxt_val[i] = (hist.size() >= MS[i]) ? 1 : 0;
            end
            hist.push_back(d);
        end else begin
            for (int i = 0; i < 3; i++) nxt_val[i] = 0;
        end
        @(posedge clk);
        exp_out = nxt_out;
        exp_val = nxt_val;
        lit_sel = ls;
        lit_out = lo;
        lit_val = lv;
        started = 1'b1;
        #1;
    endtask

    // Single compare process: model on every cycle, literal pins when tagged.
    always @(negedge clk) begin
        int a_out[3];
        int a_val[3];
        if (started) begin
            a_out[0] = int'(out0); a_val[0] = int'(val0);
            a_out[1] = int'(out1); a_val[1] = int'(val1);
            a_out[2] = int'(out2); a_val[2] = int'(val2);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (a_out[i] != exp_out[i] || a_val[i] != exp_val[i]) begin
                    errors++;
                    $display("FAIL model dut%0d t=%0t: got out=%0d valid=%0d, want out=%0d valid=%0d",
                             i, $time, a_out[i], a_val[i], exp_out[i], exp_val[i]);
                end
            end
            if (lit_sel != 0) begin
                checks++;
                if (a_out[lit_sel-1] != lit_out || a_val[lit_sel-1] != lit_val) begin
                    errors++;
                    $display("FAIL literal dut%0d t=%0t: got out=%0d valid=%0d, want out=%0d valid=%0d",
                             lit_sel - 1, $time, a_out[lit_sel-1], a_val[lit_sel-1], lit_out, lit_val);
                end
            end
        end
    end

    initial begin
        int acc;
        // Reset held with en high and live data.
        repeat (3) cyc(1, 1, 85, 1, 0, 0);

        // Ramp at M=1: first sample unprimed, then constant slope 1.
        for (int i = 0; i <= 10; i++) cyc(0, 1, i, 1, (i == 0) ? 0 : 1, (i == 0) ? 0 : 1);

        // Extremes at M=2.
        cyc(1, 0, 0);
        cyc(0, 1, -128, 2, -128, 0);
        cyc(0, 1,  127, 2,  127, 0);
        cyc(0, 1,  127, 2,  255, 1);
        cyc(0, 1, -128, 2, -255, 1);

        // Narrowed output: -128 - 127 = -255.
        cyc(1, 0, 0);
        cyc(0, 1,  127);
        cyc(0, 1, -128, 3, SAT ? -128 : 1, 1);

        // Gaps in en leave history intact.
        cyc(1, 0, 0);
        cyc(0, 1, 10, 1, 10, 0);
        repeat (3) cyc(0, 0, 99, 1, 10, 0);
        cyc(0, 1, 13, 1, 3, 1);

        // Reset inside a gap restarts priming.
        cyc(1, 0, 0);
        cyc(0, 1, 10, 1, 10, 0);
        cyc(0, 0, 0, 1, 10, 0);
        cyc(1, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 1, 13, 1, 13, 0);
        cyc(0, 1, 20, 1, 7, 1);

        // Reset with en high discards that sample.
        cyc(1, 1, 50, 1, 0, 0);
        cyc(0, 1, 60, 1, 60, 0);
        cyc(0, 1, 45, 1, -15, 1);

        // Accumulated counter ramp is recovered by M=1.
        cyc(1, 0, 0);
        acc = 0;
        for (int k = 0; k <= 10; k++) begin
            acc = acc + k;
            cyc(0, 1, acc, 1, k, (k == 0) ? 0 : 1);
        end
        cyc(0, 0, 0, 1, 10, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
